fetch_unit: RTL and testbench

FETCH_UNIT -- requirements
Module: fetch_unit

---
 rtl/fetch_unit_pkg.sv | 25 ++
 rtl/fetch_buffer.sv | 65 ++++++
 rtl/fetch_unit.sv | 97 +++++++++
 tb/tb_fetch_unit.sv | 254 +++++++++++++++++++++++++
 4 files changed

// File: rtl/fetch_unit_pkg.sv
// Shared types and constants for the instruction fetch unit and its buffer.
package fetch_unit_pkg;

  localparam int XLEN        = 32;
  localparam int INSTR_BYTES = 4;
  localparam logic [XLEN-1:0] RESET_PC_DEFAULT = 32'h0000_0000;

  typedef enum logic [1:0] {
    ST_IDLE,
    ST_REQ,
    ST_WAIT,
    ST_DROP
  } fetch_state_t;

  typedef struct packed {
    logic [XLEN-1:0] instr;
    logic [XLEN-1:0] pc;
    logic [XLEN-1:0] pc_plus4;
  } fetch_entry_t;

  function automatic logic [XLEN-1:0] word_align(input logic [XLEN-1:0] addr);
    return {addr[XLEN-1:2], 2'b00};
  endfunction

endpackage

// File: rtl/fetch_buffer.sv
// Small FIFO of fetched instructions with their PCs; flush overrides push and pop.
module fetch_buffer
  import fetch_unit_pkg::*;
#(
  parameter  int DEPTH = 2,
  localparam int PTR_W = $clog2(DEPTH),
  localparam int CNT_W = PTR_W + 1
) (
  input  logic               clk,
  input  logic               rst_n,
  input  logic               push,
  input  fetch_entry_t       push_entry,
  input  logic               pop,
  input  logic               flush,
  output fetch_entry_t       head,
  output logic [CNT_W-1:0]   count,
  output logic               full,
  output logic               empty
);

  fetch_entry_t     entry_reg [DEPTH];
  logic [PTR_W-1:0] head_ptr_reg;
  logic [PTR_W-1:0] tail_ptr_reg;
  logic [CNT_W-1:0] count_reg;
  logic             do_push;
  logic             do_pop;

  assign full    = (count_reg == CNT_W'(DEPTH));
  assign empty   = (count_reg == '0);
  assign do_pop  = pop && !empty && !flush;
  // A pop in the same cycle frees the slot, so push is legal even when full.
  assign do_push = push && (!full || do_pop) && !flush;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      head_ptr_reg <= '0;
      tail_ptr_reg <= '0;
      count_reg    <= '0;
      for (int i = 0; i < DEPTH; i++) begin
        entry_reg[i] <= '0;
      end
    end else if (flush) begin
      head_ptr_reg <= '0;
      tail_ptr_reg <= '0;
      count_reg    <= '0;
    end else begin
      if (do_push) begin
        entry_reg[tail_ptr_reg] <= push_entry;
        tail_ptr_reg            <= tail_ptr_reg + PTR_W'(1);
      end
      if (do_pop) begin
        head_ptr_reg <= head_ptr_reg + PTR_W'(1);
      end
      if (do_push && !do_pop) begin
        count_reg <= count_reg + CNT_W'(1);
      end else if (do_pop && !do_push) begin
        count_reg <= count_reg - CNT_W'(1);
      end
    end
  end

  assign head  = entry_reg[head_ptr_reg];
  assign count = count_reg;

endmodule

// File: rtl/fetch_unit.sv
// Instruction fetch: PC sequencing, one-outstanding memory request FSM and redirect handling.
module fetch_unit
  import fetch_unit_pkg::*;
#(
  parameter logic [XLEN-1:0] RESET_PC  = RESET_PC_DEFAULT,
  parameter int              BUF_DEPTH = 2
) (
  input  logic            clk,
  input  logic            rst_n,
  input  logic            PCSrc,
  input  logic [XLEN-1:0] PCTarget,
  output logic            imem_req_valid,
  input  logic            imem_req_ready,
  output logic [XLEN-1:0] imem_addr,
  input  logic            imem_rsp_valid,
  input  logic [XLEN-1:0] imem_rsp_data,
  output logic            instr_valid,
  input  logic            instr_ready,
  output logic [XLEN-1:0] instr,
  output logic [XLEN-1:0] instr_pc,
  output logic [XLEN-1:0] instr_pc_plus4
);

  localparam int CNT_W = $clog2(BUF_DEPTH) + 1;
  localparam int SUM_W = CNT_W + 1;

  fetch_state_t     state_reg;
  logic [XLEN-1:0]  fetch_pc_reg;
  logic             outstanding;
  logic             has_room;
  logic             req_fire;
  logic             push;
  logic             pop;
  fetch_entry_t     push_entry;
  fetch_entry_t     head;
  logic [CNT_W-1:0] buf_count;
  logic             buf_full;
  logic             buf_empty;

  assign outstanding = (state_reg == ST_WAIT) || (state_reg == ST_DROP);
  assign has_room    = !buf_full &&
                       ((SUM_W'(buf_count) + SUM_W'(outstanding)) < SUM_W'(BUF_DEPTH));

  // Decoded from registers only (plus the redirect strobe), never from response or decode handshakes.
  assign imem_req_valid = (state_reg == ST_REQ) && has_room && !PCSrc;
  assign imem_addr      = fetch_pc_reg;
  assign req_fire       = imem_req_valid && imem_req_ready;

  // fetch_pc already advanced past the request in flight, so it is that request's PC+4.
  assign push       = (state_reg == ST_WAIT) && imem_rsp_valid && !PCSrc;
  assign push_entry = '{instr:    imem_rsp_data,
                        pc:       fetch_pc_reg - XLEN'(INSTR_BYTES),
                        pc_plus4: fetch_pc_reg};
  assign pop        = instr_valid && instr_ready;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_reg    <= ST_IDLE;
      fetch_pc_reg <= RESET_PC;
    end else if (PCSrc) begin
      fetch_pc_reg <= word_align(PCTarget);
      // A response landing in the redirect cycle retires the stale request; nothing is left to drop.
      state_reg    <= (outstanding && !imem_rsp_valid) ? ST_DROP : ST_REQ;
    end else begin
      if (req_fire) begin
        fetch_pc_reg <= fetch_pc_reg + XLEN'(INSTR_BYTES);
      end
      case (state_reg)
        ST_IDLE:          state_reg <= ST_REQ;
        ST_REQ:           if (req_fire) state_reg <= ST_WAIT;
        ST_WAIT, ST_DROP: if (imem_rsp_valid) state_reg <= ST_REQ;
        default:          state_reg <= ST_IDLE;
      endcase
    end
  end

  fetch_buffer #(
    .DEPTH (BUF_DEPTH)
  ) u_buf (
    .clk        (clk),
    .rst_n      (rst_n),
    .push       (push),
    .push_entry (push_entry),
    .pop        (pop),
    .flush      (PCSrc),
    .head       (head),
    .count      (buf_count),
    .full       (buf_full),
    .empty      (buf_empty)
  );

  assign instr_valid    = !buf_empty;
  assign instr          = head.instr;
  assign instr_pc       = head.pc;
  assign instr_pc_plus4 = head.pc_plus4;

endmodule

// File: tb/tb_fetch_unit.sv
// Randomized bench for fetch_unit: memory responder plus a program-order reference model.
module tb_fetch_unit;

  localparam logic [31:0] RESET_PC = 32'h0000_0000;
  localparam int          DEPTH    = 2;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        PCSrc = 1'b0;
  logic [31:0] PCTarget = '0;
  logic        imem_req_valid;
  logic        imem_req_ready = 1'b0;
  logic [31:0] imem_addr;
  logic        imem_rsp_valid = 1'b0;
  logic [31:0] imem_rsp_data = '0;
  logic        instr_valid;
  logic        instr_ready = 1'b0;
  logic [31:0] instr;
  logic [31:0] instr_pc;
  logic [31:0] instr_pc_plus4;

  always #5 clk = ~clk;

  fetch_unit #(
    .RESET_PC  (RESET_PC),
    .BUF_DEPTH (DEPTH)
  ) dut (
    .clk            (clk),
    .rst_n          (rst_n),
    .PCSrc          (PCSrc),
    .PCTarget       (PCTarget),
    .imem_req_valid (imem_req_valid),
    .imem_req_ready (imem_req_ready),
    .imem_addr      (imem_addr),
    .imem_rsp_valid (imem_rsp_valid),
    .imem_rsp_data  (imem_rsp_data),
    .instr_valid    (instr_valid),
    .instr_ready    (instr_ready),
    .instr          (instr),
    .instr_pc       (instr_pc),
    .instr_pc_plus4 (instr_pc_plus4)
  );

  int n_checks = 0;
  int n_pass   = 0;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got === exp) n_pass++;
    else $display("FAIL %s: got %h expected %h", tag, got, exp);
  endtask

  // Memory contents are a fixed function of the address, so stale data is recognisable.
  function automatic logic [31:0] mem_word(input logic [31:0] a);
    return {a[7:0], a[31:8]} ^ 32'hC0DE_1234;
  endfunction

  // Stimulus knobs.
  int          ready_pct = 100, iready_pct = 100, pcsrc_pct = 0, lat_lo = 0, lat_hi = 0;
  bit          force_pcsrc = 1'b0;
  logic [31:0] force_target = '0;

  // Reference model: occupancy, outstanding request, expected fetch and decode streams.
  int          occ;
  bit          outstanding, stale;
  int          lat_cnt;
  logic [31:0] rsp_addr, exp_fetch, exp_next;
  bit          accepted;
  logic [31:0] accepted_addr;
  int          n_pop = 0;

  task automatic model_reset();
    occ = 0; outstanding = 0; stale = 0; lat_cnt = 0;
    rsp_addr = '0; exp_fetch = RESET_PC; exp_next = RESET_PC;
  endtask

  task automatic step();
    bit pop;
    @(posedge clk); #1;
    PCSrc          = force_pcsrc || ($urandom_range(0, 99) < pcsrc_pct);
    PCTarget       = force_pcsrc ? force_target : $urandom;
    imem_req_ready = ($urandom_range(0, 99) < ready_pct);
    instr_ready    = ($urandom_range(0, 99) < iready_pct);
    imem_rsp_valid = outstanding && (lat_cnt == 0);
    imem_rsp_data  = imem_rsp_valid ? mem_word(rsp_addr) : $urandom;
    @(negedge clk);
    check("instr_valid", 32'(instr_valid), 32'(occ > 0));
    check("req_valid", 32'(imem_req_valid), 32'(!PCSrc && !outstanding && occ < DEPTH));
    accepted = imem_req_valid && imem_req_ready;
    pop      = instr_valid && instr_ready && !PCSrc;
    if (pop) begin
      check("pop_pc", instr_pc, exp_next);
      check("pop_instr", instr, mem_word(exp_next));
      check("pop_pc4", instr_pc_plus4, exp_next + 32'd4);
      $display("pop pc=%h instr=%h", instr_pc, instr);
      exp_next += 32'd4;
      n_pop++;
    end
    if (imem_rsp_valid) begin
      if (!stale && !PCSrc) occ++;
      outstanding = 0;
      stale       = 0;
    end else if (outstanding) begin
      if (PCSrc) stale = 1;
      lat_cnt--;
    end
    if (pop && occ > 0) occ--;
    if (PCSrc) occ = 0;
    if (accepted) begin
      check("req_addr", imem_addr, exp_fetch);
      accepted_addr = imem_addr;
      exp_fetch    += 32'd4;
      outstanding   = 1;
      stale         = 0;
      rsp_addr      = imem_addr;
      lat_cnt       = $urandom_range(lat_lo, lat_hi);
    end
    if (PCSrc) begin
      exp_fetch = {PCTarget[31:2], 2'b00};
      exp_next  = {PCTarget[31:2], 2'b00};
    end
  endtask

  task automatic check_reset_outputs(input string tag);
    check({tag, "_req_valid"}, 32'(imem_req_valid), 32'd0);
    check({tag, "_instr_valid"}, 32'(instr_valid), 32'd0);
    check({tag, "_instr"}, instr, 32'd0);
    check({tag, "_instr_pc"}, instr_pc, 32'd0);
    check({tag, "_pc_plus4"}, instr_pc_plus4, 32'd0);
    check({tag, "_imem_addr"}, imem_addr, RESET_PC);
  endtask

  // Step until a request is accepted; returns 0 if the budget runs out.
  task automatic step_until_accept(input int budget, output bit ok);
    ok = 0;
    for (int i = 0; i < budget && !ok; i++) begin
      step();
      if (accepted) ok = 1;
    end
  endtask

  initial begin
    logic [31:0] seq [3];
    int          n_acc;
    logic [31:0] head0, pc0;
    int          pops_before;
    bit          ok;

    model_reset();
    rst_n = 1'b0;
    repeat (2) @(posedge clk);
    #1 check_reset_outputs("rst");
    @(negedge clk);
    rst_n = 1'b1;
    #1 check("idle_no_req", 32'(imem_req_valid), 32'd0);

    // Sequential fetch from reset with an always-ready memory and decode.
    n_acc = 0;
    for (int i = 0; i < 12 && n_acc < 3; i++) begin
      step();
      if (accepted) begin
        seq[n_acc] = accepted_addr;
        n_acc++;
      end
    end
    check("seq_count", 32'(n_acc), 32'd3);
    check("seq0", seq[0], RESET_PC);
    check("seq1", seq[1], RESET_PC + 32'd4);
    check("seq2", seq[2], RESET_PC + 32'd8);

    // Decode stall: buffer fills to depth, requests stop, head holds.
    iready_pct = 0;
    for (int i = 0; i < 10; i++) begin
      step();
      if (i == 3) begin
        head0 = instr;
        pc0   = instr_pc;
      end
    end
    check("stall_req", 32'(imem_req_valid), 32'd0);
    check("stall_valid", 32'(instr_valid), 32'd1);
    check("stall_head", instr, head0);
    check("stall_pc", instr_pc, pc0);
    ready_pct   = 0;
    iready_pct  = 100;
    pops_before = n_pop;
    repeat (6) step();
    check("stall_depth", 32'(n_pop - pops_before), 32'd2);

    // Redirect while waiting on a slow response.
    ready_pct = 100;
    lat_lo    = 3;
    lat_hi    = 3;
    step_until_accept(20, ok);
    check("redir_setup", 32'(ok), 32'd1);
    force_pcsrc  = 1'b1;
    force_target = 32'h0000_0102;
    step();
    force_pcsrc = 1'b0;
    lat_lo      = 0;
    lat_hi      = 0;
    step_until_accept(30, ok);
    check("redir_accept", 32'(ok), 32'd1);
    check("redir_addr", accepted_addr, 32'h0000_0100);
    repeat (8) step();

    // Address wrap at the top of the address space.
    force_pcsrc  = 1'b1;
    force_target = 32'hFFFF_FFFC;
    step();
    force_pcsrc = 1'b0;
    step_until_accept(20, ok);
    check("wrap_first", accepted_addr, 32'hFFFF_FFFC);
    step_until_accept(20, ok);
    check("wrap_next", accepted_addr, 32'h0000_0000);
    repeat (6) step();

    // Reset while waiting, with the response arriving in the same cycle.
    iready_pct = 0;
    step_until_accept(20, ok);
    check("midrst_setup", 32'(ok), 32'd1);
    @(posedge clk); #1;
    PCSrc          = 1'b0;
    imem_rsp_valid = 1'b1;
    imem_rsp_data  = mem_word(rsp_addr);
    instr_ready    = 1'b1;
    rst_n          = 1'b0;
    #1 check_reset_outputs("midrst");
    @(negedge clk);
    imem_rsp_valid = 1'b0;
    @(posedge clk);
    @(negedge clk);
    check_reset_outputs("midrst_hold");
    model_reset();
    rst_n      = 1'b1;
    iready_pct = 100;
    #1 check("midrst_idle", 32'(imem_req_valid), 32'd0);
    step_until_accept(10, ok);
    check("post_rst_addr", accepted_addr, RESET_PC);

    // Random traffic with redirects, back-pressure and variable latency.
    ready_pct  = 70;
    iready_pct = 60;
    pcsrc_pct  = 4;
    lat_lo     = 0;
    lat_hi     = 3;
    repeat (3000) step();
    check("progress", 32'(n_pop > 200), 32'd1);

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
